// File: rtl/pixel_expand_444_to_565.sv
// RGB444 -> RGB565 AXI4-Stream expander with registered skid buffer,
// start-of-frame tuser generation, frame counting and length checking.
module pixel_expand_444_to_565 #(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned PIX_W        = 20,
  parameter int unsigned FCNT_W       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axi_tvalid,
  output logic              s_axi_tready,
  input  logic [15:0]       s_axi_tdata,
  input  logic              s_axi_tlast,
  output logic              m_axi_tvalid,
  input  logic              m_axi_tready,
  output logic [15:0]       m_axi_tdata,
  output logic              m_axi_tlast,
  output logic              m_axi_tuser,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              len_err
);

  localparam logic [PIX_W:0] FP_LAST =
    (PIX_W+1)'(FRAME_PIXELS);
  localparam logic [PIX_W:0] FP_OVR =
    (PIX_W+1)'(FRAME_PIXELS + 1);

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t             out_q, out_d;
  beat_t             skid_q, skid_d;
  logic              out_vld_q, out_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic              sof_q, sof_d;
  logic              ovr_q, ovr_d;
  logic              lerr_q, lerr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [3:0]  r4, g4, b4;
  logic [15:0] rgb565;
  logic [PIX_W:0] pix_inc;
  beat_t       in_beat;
  logic        acc, xfer;
  logic        unused_hi;

  assign unused_hi = ^s_axi_tdata[15:12];

  assign r4 = s_axi_tdata[11:8];
  assign g4 = s_axi_tdata[7:4];
  assign b4 = s_axi_tdata[3:0];

  // MSB replication keeps 0 -> 0 and full-scale -> full-scale
  assign rgb565 = {r4, r4[3],
                   g4, g4[3:2],
                   b4, b4[3]};

  assign in_beat = '{data: rgb565,
                     last: s_axi_tlast,
                     user: sof_q};

  assign acc     = s_axi_tvalid && rdy_q;
  assign xfer    = out_vld_q && m_axi_tready;
  assign pix_inc = {1'b0, pix_q} + 1'b1;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_comb begin
    sof_d  = sof_q;
    pix_d  = pix_q;
    fcnt_d = fcnt_q;
    ovr_d  = ovr_q;
    lerr_d = 1'b0;
    if (acc) begin
      sof_d = s_axi_tlast;
      if (s_axi_tlast) begin
        pix_d  = '0;
        fcnt_d = fcnt_q + 1'b1;
        ovr_d  = 1'b0;
        lerr_d = (pix_inc != FP_LAST) && !ovr_q;
      end else begin
        // overrun reported once; its tlast stays silent
        if (pix_inc == FP_OVR && !ovr_q) begin
          lerr_d = 1'b1;
          ovr_d  = 1'b1;
        end
        if (!(&pix_q)) begin
          pix_d = pix_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      sof_q      <= 1'b1;
      ovr_q      <= 1'b0;
      lerr_q     <= 1'b0;
      pix_q      <= '0;
      fcnt_q     <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      sof_q      <= sof_d;
      ovr_q      <= ovr_d;
      lerr_q     <= lerr_d;
      pix_q      <= pix_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign s_axi_tready = rdy_q;
  assign m_axi_tvalid = out_vld_q;
  assign m_axi_tdata  = out_q.data;
  assign m_axi_tlast  = out_q.last;
  assign m_axi_tuser  = out_q.user;
  assign frame_cnt    = fcnt_q;
  assign len_err      = lerr_q;

endmodule
